// File: rtl/ann_pkg.sv
// Shared ANN definitions: layer sequencer state encoding and default layer dimensions.
// Also used by the neuron controller's testbench.
package ann_pkg;

  localparam int unsigned N_INPUTS_DEF  = 4;
  localparam int unsigned N_NEURONS_DEF = 3;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLR    = 4'd1;
  localparam logic [3:0] S_CLR_LO = 4'd2;
  localparam logic [3:0] S_CLR_HI = 4'd3;
  localparam logic [3:0] S_ISSUE  = 4'd4;
  localparam logic [3:0] S_MAC_LO = 4'd5;
  localparam logic [3:0] S_MAC_HI = 4'd6;
  localparam logic [3:0] S_WRITE  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  typedef enum logic [3:0] {
    StIdle  = S_IDLE,
    StClr   = S_CLR,
    StClrLo = S_CLR_LO,
    StClrHi = S_CLR_HI,
    StIssue = S_ISSUE,
    StMacLo = S_MAC_LO,
    StMacHi = S_MAC_HI,
    StWrite = S_WRITE,
    StDone  = S_DONE
  } layer_state_e;

endpackage

// File: rtl/mod_counter.sv
// Index counter with synchronous clear and increment; flags when it sits at MAX.
// It never wraps on its own: the owner clears it explicitly.
module mod_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q    = cnt_q;
  assign last = (cnt_q == WIDTH'(MAX));

endmodule

// File: rtl/layer_controller.sv
// Layer sequencer: walks every neuron through one MAC per input, handshaking with the
// neuron controller's finish flag, then strobes the result into the layer output buffer.
module layer_controller
  import ann_pkg::*;
#(
  parameter int unsigned N_INPUTS  = N_INPUTS_DEF,
  parameter int unsigned N_NEURONS = N_NEURONS_DEF,
  parameter int unsigned IW        = 2,
  parameter int unsigned NW        = 2,
  parameter int unsigned WW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          neuron_finish,
  output logic          neuron_start,
  output logic          neuron_clr,
  output logic [IW-1:0] in_idx,
  output logic [NW-1:0] neuron_idx,
  output logic [WW-1:0] w_addr,
  output logic          out_we,
  output logic          busy,
  output logic          done
);

  layer_state_e state_q, state_d;

  logic in_clr, in_inc, in_last;
  logic nrn_clr, nrn_inc, nrn_last;

  mod_counter #(
    .WIDTH (IW),
    .MAX   (N_INPUTS - 1)
  ) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (in_clr),
    .inc  (in_inc),
    .q    (in_idx),
    .last (in_last)
  );

  mod_counter #(
    .WIDTH (NW),
    .MAX   (N_NEURONS - 1)
  ) u_nrn_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (nrn_clr),
    .inc  (nrn_inc),
    .q    (neuron_idx),
    .last (nrn_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The LO/HI pairs wait for the neuron to drop and then restore finish, so a slow
  // neuron simply stretches the handshake.
  always_comb begin
    state_d      = state_q;
    neuron_start = 1'b0;
    neuron_clr   = 1'b0;
    out_we       = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    in_clr       = 1'b0;
    in_inc       = 1'b0;
    nrn_clr      = 1'b0;
    nrn_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StClr;
      end
      StClr: begin
        neuron_clr = 1'b1;
        state_d    = StClrLo;
      end
      StClrLo: begin
        if (!neuron_finish) state_d = StClrHi;
      end
      StClrHi: begin
        if (neuron_finish) state_d = StIssue;
      end
      StIssue: begin
        neuron_start = 1'b1;
        state_d      = StMacLo;
      end
      StMacLo: begin
        if (!neuron_finish) state_d = StMacHi;
      end
      StMacHi: begin
        if (neuron_finish) begin
          if (in_last) begin
            state_d = StWrite;
          end else begin
            in_inc  = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StWrite: begin
        // neuron_idx still addresses the neuron just finished while out_we is high.
        out_we = 1'b1;
        in_clr = 1'b1;
        if (nrn_last) begin
          state_d = StDone;
        end else begin
          nrn_inc = 1'b1;
          state_d = StClr;
        end
      end
      StDone: begin
        done    = 1'b1;
        nrn_clr = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign w_addr = WW'(WW'(neuron_idx) * WW'(N_INPUTS) + WW'(in_idx));

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: behavioural neuron with per-transaction stalls, and a
// timing/address model derived from the cycle rules of the sequencer.
module tb_layer_controller;

  localparam int N_IN  = 4;
  localparam int N_NR  = 3;
  localparam int N_MAC = N_IN * N_NR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       neuron_finish = 1'b1;
  logic       neuron_start, neuron_clr, out_we, busy, done;
  logic [1:0] in_idx, neuron_idx;
  logic [3:0] w_addr;

  layer_controller #(
    .N_INPUTS  (N_IN),
    .N_NEURONS (N_NR),
    .IW        (2),
    .NW        (2),
    .WW        (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .neuron_finish (neuron_finish),
    .neuron_start  (neuron_start),
    .neuron_clr    (neuron_clr),
    .in_idx        (in_idx),
    .neuron_idx    (neuron_idx),
    .w_addr        (w_addr),
    .out_we        (out_we),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Neuron model: finish drops the cycle after a pulse, returns after 1 (clear) or
  // 4 (MAC) cycles plus any programmed stall.
  int stall_clr[N_NR];
  int stall_mac[N_MAC];
  int clr_n = 0, mac_n = 0, rem = 0;

  always @(negedge clk) begin
    if (rst) begin
      neuron_finish <= 1'b1;
      rem           <= 0;
      clr_n         <= 0;
      mac_n         <= 0;
    end else begin
      if (!busy) begin
        clr_n <= 0;
        mac_n <= 0;
      end
      if (neuron_clr) begin
        neuron_finish <= 1'b0;
        rem           <= 2 + ((clr_n < N_NR) ? stall_clr[clr_n] : 0);
        clr_n         <= clr_n + 1;
      end else if (neuron_start) begin
        neuron_finish <= 1'b0;
        rem           <= 5 + ((mac_n < N_MAC) ? stall_mac[mac_n] : 0);
        mac_n         <= mac_n + 1;
      end else if (rem > 0) begin
        if (rem == 1) neuron_finish <= 1'b1;
        rem <= rem - 1;
      end
    end
  end

  // Event monitor, cycle numbers relative to the cycle in which start was driven.
  int o_clr[$], o_st[$], o_addr[$], o_in[$], o_nr[$], o_we[$], o_wn[$], o_done[$];
  int overlap = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (neuron_start) begin
        o_st.push_back(cyc - base);
        o_addr.push_back(int'(w_addr));
        o_in.push_back(int'(in_idx));
        o_nr.push_back(int'(neuron_idx));
      end
      if (neuron_clr) o_clr.push_back(cyc - base);
      if (out_we) begin
        o_we.push_back(cyc - base);
        o_wn.push_back(int'(neuron_idx));
      end
      if (done) o_done.push_back(cyc - base);
      if (neuron_start && neuron_clr) overlap <= overlap + 1;
    end
  end

  task automatic clear_stalls();
    foreach (stall_clr[n]) stall_clr[n] = 0;
    foreach (stall_mac[k]) stall_mac[k] = 0;
  endtask

  task automatic begin_capture();
    @(negedge clk);
    o_clr.delete(); o_st.delete(); o_addr.delete(); o_in.delete();
    o_nr.delete(); o_we.delete(); o_wn.delete(); o_done.delete();
    base   = cyc;
    mon_en = 1'b1;
  endtask

  // Runs one layer and checks every event against the model.
  // mode 0: single start pulse; mode 2: random start toggling while busy.
  task automatic run_layer(input int mode, input string tag);
    int e_clr[$], e_st[$], e_addr[$], e_in[$], e_nr[$], e_we[$], e_wn[$];
    int e_done, t, k, m;
    bit seen;
    t = 1;
    k = 0;
    for (int n = 0; n < N_NR; n++) begin
      e_clr.push_back(t);
      t += 3 + stall_clr[n];
      for (int i = 0; i < N_IN; i++) begin
        e_st.push_back(t);
        e_addr.push_back(n * N_IN + i);
        e_in.push_back(i);
        e_nr.push_back(n);
        t += 6 + stall_mac[k];
        k++;
      end
      e_we.push_back(t);
      e_wn.push_back(n);
      t += 1;
    end
    e_done = t;

    begin_capture();
    start = 1'b1;
    @(negedge clk);
    start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mode == 2) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no done, want done within 3000 cycles", tag);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %b, want 0", tag, busy);
    end
    #1;
    mon_en = 1'b0;

    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL %s start_clr_overlap: got %0d cycles, want 0", tag, overlap);
    end
    checks++;
    if (o_clr.size() != e_clr.size()) begin
      errors++;
      $display("FAIL %s clr_count: got %0d, want %0d", tag, o_clr.size(), e_clr.size());
    end
    m = (o_clr.size() < e_clr.size()) ? o_clr.size() : e_clr.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (o_clr[i] != e_clr[i]) begin
        errors++;
        $display("FAIL %s clr_cycle[%0d]: got %0d, want %0d", tag, i, o_clr[i], e_clr[i]);
      end
    end
    checks++;
    if (o_st.size() != e_st.size()) begin
      errors++;
      $display("FAIL %s start_count: got %0d, want %0d", tag, o_st.size(), e_st.size());
    end
    m = (o_st.size() < e_st.size()) ? o_st.size() : e_st.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (o_st[i] != e_st[i] || o_addr[i] != e_addr[i] || o_in[i] != e_in[i] ||
          o_nr[i] != e_nr[i]) begin
        errors++;
        $display("FAIL %s mac[%0d] cyc/w_addr/in/nrn: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d",
                 tag, i, o_st[i], o_addr[i], o_in[i], o_nr[i],
                 e_st[i], e_addr[i], e_in[i], e_nr[i]);
      end
    end
    checks++;
    if (o_we.size() != e_we.size()) begin
      errors++;
      $display("FAIL %s we_count: got %0d, want %0d", tag, o_we.size(), e_we.size());
    end
    m = (o_we.size() < e_we.size()) ? o_we.size() : e_we.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (o_we[i] != e_we[i] || o_wn[i] != e_wn[i]) begin
        errors++;
        $display("FAIL %s we[%0d] cyc/nrn: got %0d/%0d, want %0d/%0d",
                 tag, i, o_we[i], o_wn[i], e_we[i], e_wn[i]);
      end
    end
    checks++;
    if (o_done.size() != 1 || o_done[0] != e_done) begin
      errors++;
      $display("FAIL %s done: got %0d pulses first at %0d, want 1 at %0d",
               tag, o_done.size(), (o_done.size() > 0) ? o_done[0] : -1, e_done);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({neuron_start, neuron_clr, in_idx, neuron_idx, w_addr, out_we, busy, done} !== 15'd0)
      begin
        errors++;
        $display("FAIL reset_idle[%0d]: got outputs %b, want all 0", i,
                 {neuron_start, neuron_clr, in_idx, neuron_idx, w_addr, out_we, busy, done});
      end
    end
  endtask

  task automatic test_full_layer();
    clear_stalls();
    run_layer(0, "full_layer");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_we.size() <= i || o_we[i] != 28 * (i + 1)) begin
        errors++;
        $display("FAIL full_layer out_we_cycle[%0d]: got %0d, want %0d", i,
                 (o_we.size() > i) ? o_we[i] : -1, 28 * (i + 1));
      end
    end
    checks++;
    if (o_done.size() < 1 || o_done[0] != 85) begin
      errors++;
      $display("FAIL full_layer done_cycle: got %0d, want 85",
               (o_done.size() > 0) ? o_done[0] : -1);
    end
  endtask

  task automatic stall_watch();
    bit hit = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (neuron_start && w_addr == 4'd1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL stall issue_mac1: got no issue of w_addr 1, want one");
    end else begin
      for (int j = 0; j < 25; j++) begin
        @(negedge clk);
        checks++;
        if ({neuron_start, neuron_idx, in_idx, w_addr} !== {1'b0, 2'd0, 2'd1, 4'd1}) begin
          errors++;
          $display("FAIL stall hold[%0d] start/nrn/in/addr: got %b/%0d/%0d/%0d, want 0/0/1/1",
                   j, neuron_start, neuron_idx, in_idx, w_addr);
        end
      end
    end
  endtask

  task automatic test_stall();
    clear_stalls();
    stall_mac[1] = 20;
    fork
      run_layer(0, "stall");
      stall_watch();
    join
    checks++;
    if (o_done.size() < 1 || o_done[0] != 105) begin
      errors++;
      $display("FAIL stall done_cycle: got %0d, want 105",
               (o_done.size() > 0) ? o_done[0] : -1);
    end
    clear_stalls();
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    clear_stalls();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (neuron_start && neuron_idx == 2'd1 && in_idx == 2'd1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL async_rst reach_mac: got no MAC 1 on neuron 1, want one");
    end
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL async_rst busy_before: got %b, want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({neuron_start, neuron_clr, in_idx, neuron_idx, w_addr, out_we, busy, done} !== 15'd0)
    begin
      errors++;
      $display("FAIL async_rst outputs: got %b, want all 0",
               {neuron_start, neuron_clr, in_idx, neuron_idx, w_addr, out_we, busy, done});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_layer(0, "after_rst");
  endtask

  task automatic test_busy_start();
    clear_stalls();
    run_layer(2, "busy_start");
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    clear_stalls();
    begin_capture();
    start = 1'b1;
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || cyc - base != 85) begin
      errors++;
      $display("FAIL b2b first_done: got seen=%0d at %0d, want at 85", seen, cyc - base);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle_gap_busy: got %b, want 0", busy);
    end
    @(negedge clk);
    checks++;
    if (neuron_clr !== 1'b1) begin
      errors++;
      $display("FAIL b2b relaunch_clr at %0d: got %b, want 1", cyc - base, neuron_clr);
    end
    start = 1'b0;
    seen  = 1'b0;
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || cyc - base != 171) begin
      errors++;
      $display("FAIL b2b second_done: got seen=%0d at %0d, want at 171", seen, cyc - base);
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (o_we.size() != 6 || o_done.size() != 2 || o_clr.size() != 6) begin
      errors++;
      $display("FAIL b2b counts we/done/clr: got %0d/%0d/%0d, want 6/2/6",
               o_we.size(), o_done.size(), o_clr.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      foreach (stall_clr[n]) stall_clr[n] = $urandom_range(0, 3);
      foreach (stall_mac[k]) stall_mac[k] = $urandom_range(0, 5);
      run_layer((it % 2 == 1) ? 2 : 0, "random");
    end
    clear_stalls();
  endtask

  initial begin
    clear_stalls();
    test_reset();
    test_full_layer();
    test_stall();
    test_async_reset();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
